// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, FSM encoding, canonical NOP.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: sequential +4 advance, redirect steering with deferral while a request
// is stalled on the memory handshake, and redirect alignment check.
module ifu_pc_reg #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            hold_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] target;

  assign target     = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign misalign_d = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (redirect_valid_i) begin
      // The address must stay stable until the request handshake; park the target until then.
      if (hold_i) begin
        pend_d    = 1'b1;
        pend_pc_d = target;
      end else begin
        pc_d   = target;
        pend_d = 1'b0;
      end
    end else if (pend_q && !hold_i) begin
      pc_d   = pend_pc_q;
      pend_d = 1'b0;
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one memory read in flight, fetched word held for the
// decoder under valid/ready, redirects discard any outstanding response via the drop flag.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign
);

  ifu_state_e      state_q, state_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] pc;
  logic            pc_hold;
  logic            pc_inc;

  assign pc_hold = (state_q == StReq) && !imem_req_ready;
  assign pc_inc  = (state_q == StHold) && inst_ready;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .hold_i           (pc_hold),
    .inc_i            (pc_inc),
    .pc_o             (pc),
    .misalign_o       (fetch_misalign)
  );

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect_valid) drop_d = 1'b1;
        if (imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc;
            state_d   = StHold;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (inst_ready || redirect_valid) state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == StHold);
  assign instruction    = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule
